endp_flit_injector: RTL and testbench
=====================================

Name: endp_flit_injector

Overview:
- Parametrised tile-to-NoC injection endpoint for the MPSoC top level; one instance per endpoint, sitting between a tile's send interface and the router local input port.
- Buffers tile flits in per-VC FIFOs and forwards them under credit-based flow control, one flit per cycle, with round-robin arbitration across VCs.
- Adds packet-boundary-aware enable gating and per-endpoint statistics and error flags that the current fixed 4-tile wiring does not provide.

Parameters:
- V, 2, number of virtual channels (1..8).
- B, 4, router input buffer depth per VC; this is the initial credit count.
- Fpay, 32, payload width.
- DEPTH, 4, local FIFO depth per VC; must be a power of 2 and at least 2.
- CNTw, 16, width of the sent-packet statistics counter.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- en  in  1  injection enable (from processors_en); gates new packets only.
- tile_flit  in  Fpay+2  {hdr, tail, payload}; hdr is the MSB.
- tile_vc  in  log2(V) (minimum 1)  target VC index.
- tile_wr  in  1  write strobe.
- tile_ready  out  V  per-VC FIFO not full.
- flit_out  out  Fpay+2+V  {hdr, tail, vc_onehot[V-1:0], payload}; 36 bits at the defaults.
- flit_out_wr  out  1  flit valid this cycle.
- credit_in  in  V  one-cycle credit return pulse per VC.
- pck_sent_cnt  out  CNTw  count of tail flits sent.
- err  out  2  sticky error bits: [0] write to a full FIFO, [1] credit overflow.

Behaviour:
- Reset values: all FIFOs empty; credit[v] = B; round-robin pointer = 0; in_pck[v] = 0; flit_out = 0; flit_out_wr = 0; pck_sent_cnt = 0; err = 0; tile_ready = all ones.
- Write path: when tile_wr = 1 and FIFO[tile_vc] is not full, push. If that FIFO is full, drop the flit and set err[0].
- tile_ready[v] is combinational: not full.
- A flit written in cycle N is eligible for arbitration in cycle N+1.
- Eligibility: VC v is eligible when FIFO[v] is not empty and credit[v] > 0, and additionally either:
  - in_pck[v] = 1 (mid-packet), or
  - the head flit has hdr = 1 and en = 1.
- Gating: en = 0 never stalls a packet already in progress; it blocks new headers only.
- Head flit with hdr = 0 while in_pck[v] = 0 is a protocol violation. It is forwarded unchanged, and the test plan covers it as don't-care.
- Arbitration:
  - Round-robin starts at pointer p.
  - The winner w pops its FIFO.
  - flit_out and flit_out_wr are registered: the flit appears in the cycle after the grant (output latency 1).
  - Pointer update: p <= (w+1) mod V on grant; unchanged when there is no grant.
- VC field: flit_out VC field = onehot(w).
- Packet state:
  - A header flit sets in_pck[w].
  - A tail flit clears in_pck[w].
  - A single-flit packet (hdr = 1 and tail = 1) leaves in_pck[w] = 0.
- Credits:
  - A send on v decrements credit[v]; credit_in[v] increments it.
  - A simultaneous send and credit on the same v leaves the count unchanged.
  - Credit counter width is log2(B+1).
  - An increment that would exceed B saturates at B and sets err[1].
- Statistics: pck_sent_cnt increments on every sent flit with tail = 1 and wraps modulo 2^CNTw.
- Simultaneous push and pop on the same FIFO is allowed in any occupancy state:
  - When full, the pop frees the slot first, so the push succeeds.
  - When empty, the pushed flit is not poppable in that same cycle.
- Reset asserted mid-packet: all state returns to reset values immediately and asynchronously; partially sent packets are abandoned. Network recovery is a system-level concern.
- Idle behaviour: flit_out_wr = 0 whenever there is no grant; flit_out holds its last value.

Test Plan:
- Single-flit packet: reset; write {hdr=1, tail=1, payload=32'hA5A5_0001} to VC1 -> two cycles after tile_wr, flit_out_wr = 1, flit_out = {1,1,2'b10,32'hA5A5_0001}, pck_sent_cnt = 1, credit[1] = 3.
- Credit exhaustion: with no credit_in, send a 6-flit packet on VC0 (B=4) -> exactly 4 flits out, then stall. Pulse credit_in[0] twice -> the remaining 2 flits are sent, including the tail; pck_sent_cnt = 1.
- Round-robin fairness: both VCs are loaded with 4-flit packets and credits are returned every cycle -> output VC field alternates 01, 10, 01, 10 …, starting with VC0.
- Enable gating: en = 0 after the VC0 header is sent, and a new packet is queued on VC1 -> VC0 finishes through its tail while VC1 sends nothing. Raise en -> VC1 header appears within 2 cycles.
- Errors: write 5 flits to VC0 with DEPTH=4 while credit = 0 -> err[0] = 1 and the 5th flit is dropped. Pulse credit_in[1] while credit[1] = 4 -> err[1] = 1 and credit stays 4.
- Async reset mid-packet: assert reset between clock edges during a transfer -> flit_out_wr = 0, err = 0, pck_sent_cnt = 0, tile_ready = 2'b11 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/endp_flit_injector.sv
// Tile-to-NoC injection endpoint: per-VC flit FIFOs, credit-based flow control,
// round-robin VC arbitration, packet-aware enable gating, statistics and sticky errors.
module endp_flit_injector #(
   parameter  int V     = 2,
   parameter  int B     = 4,
   parameter  int Fpay  = 32,
   parameter  int DEPTH = 4,
   parameter  int CNTw  = 16,
   localparam int VW    = (V > 1) ? $clog2(V) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [Fpay+1:0]       tile_flit,
   input  logic [VW-1:0]         tile_vc,
   input  logic                  tile_wr,
   output logic [V-1:0]          tile_ready,
   output logic [Fpay+V+1:0]     flit_out,
   output logic                  flit_out_wr,
   input  logic [V-1:0]          credit_in,
   output logic [CNTw-1:0]       pck_sent_cnt,
   output logic [1:0]            err
);

   localparam int CW = $clog2(B + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = Fpay + 2;

   logic [V-1:0]          w_full;
   logic [V-1:0]          w_elig;
   logic [V-1:0]          w_pop;
   logic [V-1:0]          w_drop;
   logic [V-1:0]          w_ovf;
   logic [V-1:0][FW-1:0]  w_head;

   logic                  w_gnt;
   logic [VW-1:0]         w_win;
   logic [VW-1:0]         w_idx;
   logic [VW-1:0]         w_nxt;
   logic [FW-1:0]         w_sel;
   logic [V-1:0]          w_oh;
   int                    w_sum;
   logic [VW-1:0]         r_ptr;

   for (genvar v = 0; v < V; v++) begin : g_vc
      logic [FW-1:0] r_mem [DEPTH];
      logic [AW:0]   r_wp;
      logic [AW:0]   r_rp;
      logic [CW-1:0] r_credit;
      logic          r_in_pck;
      logic [AW:0]   w_cnt;
      logic          w_empty;
      logic          w_push;

      assign w_cnt     = r_wp - r_rp;
      assign w_full[v] = (w_cnt == (AW+1)'(DEPTH));
      assign w_empty   = (w_cnt == '0);
      assign w_head[v] = r_mem[r_rp[AW-1:0]];
      assign w_pop[v]  = w_gnt && (w_win == VW'(v));
      // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
      assign w_push    = tile_wr && (tile_vc == VW'(v)) && (!w_full[v] || w_pop[v]);
      assign w_drop[v] = tile_wr && (tile_vc == VW'(v)) && w_full[v] && !w_pop[v];
      assign w_ovf[v]  = credit_in[v] && !w_pop[v] && (r_credit == CW'(B));
      // en only holds back a fresh header; stray non-header flits drain rather than wedge the VC.
      assign w_elig[v] = !w_empty && (r_credit != '0) &&
                         (r_in_pck || !w_head[v][FW-1] || en);

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_credit <= CW'(B);
            r_in_pck <= 1'b0;
         end else begin
            if (w_push)   r_wp <= r_wp + 1'b1;
            if (w_pop[v]) r_rp <= r_rp + 1'b1;
            if (w_pop[v] && !credit_in[v])
               r_credit <= r_credit - 1'b1;
            else if (credit_in[v] && !w_pop[v] && (r_credit != CW'(B)))
               r_credit <= r_credit + 1'b1;
            if (w_pop[v]) begin
               if (w_head[v][FW-2])      r_in_pck <= 1'b0;
               else if (w_head[v][FW-1]) r_in_pck <= 1'b1;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (w_push) r_mem[r_wp[AW-1:0]] <= tile_flit;
      end
   end

   assign tile_ready = ~w_full;

   // Round-robin: first eligible VC at or after the pointer wins.
   always_comb begin
      w_gnt = 1'b0;
      w_win = '0;
      w_sum = 0;
      w_idx = '0;
      for (int i = 0; i < V; i++) begin
         w_sum = int'(r_ptr) + i;
         if (w_sum >= V) w_sum = w_sum - V;
         w_idx = VW'(w_sum);
         if (!w_gnt && w_elig[w_idx]) begin
            w_gnt = 1'b1;
            w_win = w_idx;
         end
      end
   end

   assign w_nxt = (w_win == VW'(V - 1)) ? '0 : w_win + 1'b1;
   assign w_sel = w_head[w_win];
   assign w_oh  = V'(1) << w_win;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flit_out     <= '0;
         flit_out_wr  <= 1'b0;
         pck_sent_cnt <= '0;
         err          <= '0;
         r_ptr        <= '0;
      end else begin
         flit_out_wr <= w_gnt;
         if (w_gnt) begin
            flit_out <= {w_sel[FW-1], w_sel[FW-2], w_oh, w_sel[Fpay-1:0]};
            r_ptr    <= w_nxt;
            if (w_sel[FW-2]) pck_sent_cnt <= pck_sent_cnt + 1'b1;
         end
         err <= err | {|w_ovf, |w_drop};
      end
   end

endmodule

// File: tb/tb_endp_flit_injector.sv
// Directed bench for endp_flit_injector at default parameters (V=2, B=4, Fpay=32, DEPTH=4).
module tb_endp_flit_injector;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [33:0] tile_flit;
   logic [0:0]  tile_vc;
   logic        tile_wr;
   logic [1:0]  tile_ready;
   logic [35:0] flit_out;
   logic        flit_out_wr;
   logic [1:0]  credit_in;
   logic [15:0] pck_sent_cnt;
   logic [1:0]  err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [35:0] q[$];

   endp_flit_injector dut (
      .clk(clk), .reset(reset), .en(en),
      .tile_flit(tile_flit), .tile_vc(tile_vc), .tile_wr(tile_wr),
      .tile_ready(tile_ready), .flit_out(flit_out), .flit_out_wr(flit_out_wr),
      .credit_in(credit_in), .pck_sent_cnt(pck_sent_cnt), .err(err)
   );

   always #5 clk = ~clk;

   // Sent-flit log, sampled mid-cycle.
   always @(negedge clk) if (!reset && flit_out_wr) q.push_back(flit_out);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic vc, input logic hdr, input logic tail, input logic [31:0] pay);
      tile_vc   = vc;
      tile_flit = {hdr, tail, pay};
      tile_wr   = 1'b1;
      tick();
      tile_wr   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      q.delete();
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; tile_wr = 1'b0; tile_vc = '0; tile_flit = '0; credit_in = '0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_wr",    64'(flit_out_wr),  64'd0);
      chk("rst_flit",  64'(flit_out),     64'd0);
      chk("rst_cnt",   64'(pck_sent_cnt), 64'd0);
      chk("rst_err",   64'(err),          64'd0);
      chk("rst_ready", 64'(tile_ready),   64'd3);

      // single-flit packet on VC1
      wr(1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
      chk("sf_lat0", 64'(flit_out_wr), 64'd0);
      tick();
      chk("sf_wr",   64'(flit_out_wr), 64'd1);
      chk("sf_flit", 64'(flit_out),    64'h0_E_A5A5_0001);
      chk("sf_cnt",  64'(pck_sent_cnt), 64'd1);
      chk("sf_cred", 64'(dut.g_vc[1].r_credit), 64'd3);
      tick();
      chk("sf_idle_wr",   64'(flit_out_wr), 64'd0);
      chk("sf_idle_hold", 64'(flit_out),    64'h0_E_A5A5_0001);
      credit_in = 2'b10; tick(); credit_in = 2'b00;
      chk("sf_cred_ret", 64'(dut.g_vc[1].r_credit), 64'd4);
      chk("sf_no_err",   64'(err), 64'd0);

      // credit exhaustion: 6-flit packet on VC0
      q.delete();
      wr(1'b0, 1'b1, 1'b0, 32'h100);
      for (int i = 1; i < 5; i++) wr(1'b0, 1'b0, 1'b0, 32'h100 + 32'(i));
      wr(1'b0, 1'b0, 1'b1, 32'h105);
      repeat (4) tick();
      chk("ce_stall_n", 64'(q.size()), 64'd4);
      chk("ce_q3",      64'(q[3]),     64'h0_1_0000_0103);
      chk("ce_cred0",   64'(dut.g_vc[0].r_credit), 64'd0);
      credit_in = 2'b01; tick(); credit_in = 2'b00; tick();
      credit_in = 2'b01; tick(); credit_in = 2'b00;
      repeat (3) tick();
      chk("ce_total_n", 64'(q.size()), 64'd6);
      chk("ce_q4",      64'(q[4]),     64'h0_1_0000_0104);
      chk("ce_tail",    64'(q[5]),     64'h0_5_0000_0105);
      chk("ce_cnt",     64'(pck_sent_cnt), 64'd2);
      credit_in = 2'b01; repeat (4) tick(); credit_in = 2'b00;
      chk("ce_cred_full", 64'(dut.g_vc[0].r_credit), 64'd4);
      chk("ce_no_err",    64'(err), 64'd0);

      // round-robin fairness, both VCs preloaded while headers are gated
      do_reset();
      en = 1'b0;
      for (int i = 0; i < 4; i++) wr(1'b0, (i == 0), (i == 3), 32'h300 + 32'(i));
      for (int i = 0; i < 4; i++) wr(1'b1, (i == 0), (i == 3), 32'h310 + 32'(i));
      chk("rr_full_ready", 64'(tile_ready),  64'd0);
      chk("rr_gated",      64'(flit_out_wr), 64'd0);
      en = 1'b1;
      repeat (10) tick();
      chk("rr_n", 64'(q.size()), 64'd8);
      for (int i = 0; i < 8; i++) begin
         logic [35:0] f;
         f = (i < q.size()) ? q[i] : 36'h0;
         chk($sformatf("rr_vc%0d", i),  64'(f[33:32]), (i % 2) ? 64'd2 : 64'd1);
         chk($sformatf("rr_pay%0d", i), 64'(f[31:0]),  ((i % 2) ? 64'h310 : 64'h300) + 64'(i / 2));
      end
      chk("rr_cnt", 64'(pck_sent_cnt), 64'd2);

      // enable gating
      do_reset();
      en = 1'b1;
      wr(1'b0, 1'b1, 1'b0, 32'h400);
      tick();
      en = 1'b0;
      wr(1'b1, 1'b1, 1'b0, 32'h410);
      wr(1'b1, 1'b0, 1'b1, 32'h411);
      wr(1'b0, 1'b0, 1'b0, 32'h401);
      wr(1'b0, 1'b0, 1'b1, 32'h402);
      repeat (4) tick();
      chk("eg_n",   64'(q.size()), 64'd3);
      chk("eg_q0",  64'(q[0]), 64'h0_9_0000_0400);
      chk("eg_q1",  64'(q[1]), 64'h0_1_0000_0401);
      chk("eg_q2",  64'(q[2]), 64'h0_5_0000_0402);
      chk("eg_cnt", 64'(pck_sent_cnt), 64'd1);
      en = 1'b1;
      tick(); tick();
      chk("eg_vc1_n",   64'(q.size()), 64'd4);
      chk("eg_vc1_hdr", 64'(q.size() > 3 ? q[3] : 36'h0), 64'h0_A_0000_0410);
      repeat (2) tick();
      chk("eg_cnt2", 64'(pck_sent_cnt), 64'd2);

      // errors: overfill VC0 while headers are held, then credit overflow on VC1
      do_reset();
      en = 1'b0;
      for (int i = 0; i < 4; i++) wr(1'b0, 1'b1, 1'b1, 32'h500 + 32'(i));
      chk("er_ready", 64'(tile_ready), 64'd2);
      chk("er_none",  64'(err), 64'd0);
      wr(1'b0, 1'b1, 1'b1, 32'h504);
      chk("er_drop", 64'(err), 64'd1);
      en = 1'b1;
      repeat (6) tick();
      chk("er_n",    64'(q.size()), 64'd4);
      chk("er_last", 64'(q.size() > 3 ? q[3] : 36'h0), 64'h0_D_0000_0503);
      chk("er_cnt",  64'(pck_sent_cnt), 64'd4);
      credit_in = 2'b10; tick(); credit_in = 2'b00;
      chk("er_ovf",  64'(err), 64'd3);
      chk("er_sat",  64'(dut.g_vc[1].r_credit), 64'd4);

      // asynchronous reset mid-transfer
      wr(1'b1, 1'b1, 1'b0, 32'h600);
      tick();
      chk("ar_busy", 64'(flit_out_wr), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk("ar_wr",    64'(flit_out_wr),  64'd0);
      chk("ar_flit",  64'(flit_out),     64'd0);
      chk("ar_err",   64'(err),          64'd0);
      chk("ar_cnt",   64'(pck_sent_cnt), 64'd0);
      chk("ar_ready", 64'(tile_ready),   64'd3);
      #3 reset = 1'b0;
      tick(); tick();
      chk("ar_quiet", 64'(flit_out_wr), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
